ttehash_table: RTL
==================

Name: ttehash_table

Overview:
- TTE flow hash table; the responder end of the register-side hash interface.
- Accepts single-cycle hash_update and hash_clear pulses carrying flow/hash, and services ttehash_req (table re-init) with a 4-phase ttehash_ack.
- Gives the TTE classifier a pipelined exact-match lookup: hash index plus full flow key in, hit flag out.

Parameters:
- ADDR_W, 10, hash index width; table depth = 2^ADDR_W.
- FLOW_W, 120, flow key width.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- flow  input  FLOW_W  key written on hash_update.
- hash  input  ADDR_W  entry index for hash_update / hash_clear.
- hash_update  input  1  single-cycle pulse: write flow at hash, mark valid.
- hash_clear  input  1  single-cycle pulse: invalidate entry at hash.
- ttehash_req  input  1  table re-init request, level, held until ack.
- ttehash_ack  output  1  re-init complete, held until req deasserts.
- lk_valid  input  1  lookup request strobe.
- lk_hash  input  ADDR_W  lookup index.
- lk_flow  input  FLOW_W  lookup key.
- lk_res_valid  output  1  lookup result strobe.
- lk_hit  output  1  valid entry whose key equals lk_flow.
- busy  output  1  high in SWEEP or ACK.
- entry_cnt  output  ADDR_W+1  number of valid entries.

Behaviour:
- Storage:
  - Key RAM DEPTH x FLOW_W, synchronous read, not reset.
  - Valid bits in a DEPTH-bit flop vector with combinational read.
- Reset (rst sampled high at posedge):
  - Valid vector all 0, state IDLE.
  - ttehash_ack=0, lk_res_valid=0, lk_hit=0, entry_cnt=0, busy=0.
  - Reset mid-sweep aborts the sweep; no ack is issued.
- FSM states IDLE, SWEEP, ACK:
  - IDLE, ttehash_req=1 at edge N: go to SWEEP; sweep address=0; entry_cnt=0.
  - SWEEP: clear valid[addr] each cycle, addr+1. Address DEPTH-1 is cleared at edge N+DEPTH, then go to ACK. ttehash_ack=1 from edge N+DEPTH+1.
  - ACK: ttehash_ack held 1 until ttehash_req sampled 0; then ack=0 and go to IDLE on that edge.
  - ttehash_req dropping during SWEEP does not abort the sweep; ACK is still entered, and ack drops on the next edge.
  - ttehash_req still high on return to IDLE starts a new sweep; the requester must drop req first.
- Updates, IDLE only:
  - hash_update: RAM[hash]<=flow, valid[hash]<=1. entry_cnt+1 only if the entry was invalid; overwriting a valid entry leaves the count unchanged.
  - hash_clear: valid[hash]<=0. entry_cnt-1 only if the entry was valid.
  - Both pulses in the same cycle: clear wins, no RAM write.
  - Pulses during SWEEP/ACK are dropped.
- Lookup, 2-cycle latency, one per cycle, fully pipelined:
  - Edge T: RAM read of lk_hash; register valid[lk_hash] and lk_flow.
  - Edge T+1: lk_res_valid=1; lk_hit = stored valid & (RAM key == registered lk_flow).
  - Same-cycle write to the same index as a lookup: lookup sees old data and old valid (read-before-write).
  - Lookups during SWEEP/ACK return lk_res_valid=1, lk_hit=0.
  - lk_res_valid=0 whenever no lookup was issued two cycles earlier; lk_hit=0 whenever lk_res_valid=0.
- entry_cnt never wraps; maximum value DEPTH.

Optional Feature:
- Macro TTEHASH_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt[15:0], reset 0.
  - Increments once per cycle in which hash_update or hash_clear is dropped because busy=1.
  - Saturates at 16'hFFFF; cleared only by rst.
- Undefined: port and logic absent; dropped pulses are silently discarded.

Test Plan:
- Update idx 5 with flow 120'h1234, then lookup idx 5 with key 120'h1234 at edge T → lk_res_valid=1, lk_hit=1 at T+2; entry_cnt=1. Key 120'h1235 → lk_hit=0.
- Update idx 5 twice, then clear idx 5 twice → entry_cnt goes 1,1,0,0; a later lookup on idx 5 misses.
- Update and clear idx 7 in the same cycle → valid[7]=0, entry_cnt unchanged; a lookup 2 cycles later misses.
- Fill 3 entries, raise ttehash_req at edge N → busy=1 at N+1; ttehash_ack=1 at N+1025 (DEPTH=1024); entry_cnt=0. Drop req → ack=0 and busy=0 on the next edge; all 3 lookups miss.
- hash_update at idx 9 during SWEEP → entry absent after ack; with TTEHASH_DROP_CNT_EN, drop_cnt=1.
- Assert rst at sweep address 300 → IDLE, ack never asserted, entry_cnt=0; a lookup on a previously written index misses.

Source files
------------

// File: rtl/ttehash_if.sv
// Register-side hash interface plus the classifier lookup channel of the TTE flow hash table.
// With TTEHASH_DROP_CNT_EN defined, the interface also carries drop_cnt.
interface ttehash_if #(
    parameter int ADDR_W = 10,
    parameter int FLOW_W = 120
);
    logic [FLOW_W-1:0] flow;
    logic [ADDR_W-1:0] hash;
    logic              hash_update;
    logic              hash_clear;
    logic              ttehash_req;
    logic              ttehash_ack;
    logic              lk_valid;
    logic [ADDR_W-1:0] lk_hash;
    logic [FLOW_W-1:0] lk_flow;
    logic              lk_res_valid;
    logic              lk_hit;
    logic              busy;
    logic [ADDR_W:0]   entry_cnt;
`ifdef TTEHASH_DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    modport master (
        output flow, hash, hash_update, hash_clear, ttehash_req,
        output lk_valid, lk_hash, lk_flow,
`ifdef TTEHASH_DROP_CNT_EN
        input  drop_cnt,
`endif
        input  ttehash_ack, lk_res_valid, lk_hit, busy, entry_cnt
    );

    modport slave (
        input  flow, hash, hash_update, hash_clear, ttehash_req,
        input  lk_valid, lk_hash, lk_flow,
`ifdef TTEHASH_DROP_CNT_EN
        output drop_cnt,
`endif
        output ttehash_ack, lk_res_valid, lk_hit, busy, entry_cnt
    );
endinterface

// File: rtl/ttehash_table.sv
// TTE flow hash table: update/clear pulses, swept re-init with 4-phase ack, 2-cycle exact-match lookup.
// Define TTEHASH_DROP_CNT_EN to add a saturating count of pulses dropped while busy.
module ttehash_table #(
    parameter int ADDR_W = 10,
    parameter int FLOW_W = 120
) (
    input  logic     clk,
    input  logic     rst,
    ttehash_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, SWEEP, ACK} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0]  valid_q;
    logic [FLOW_W-1:0] mem [DEPTH];
    logic [FLOW_W-1:0] rd_key_q, s1_flow_q;
    logic              s1_vld_q, s1_valid_q, res_vld_q, hit_q;
    logic              idle, do_clr, do_upd, cur_valid;

    assign idle      = (state_q == IDLE);
    assign do_clr    = idle && bus.hash_clear;
    // clear dominates a simultaneous update, including the RAM write
    assign do_upd    = idle && bus.hash_update && !bus.hash_clear;
    assign cur_valid = valid_q[bus.hash];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (do_clr && cur_valid) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (do_upd && !cur_valid && cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (bus.ttehash_req) begin
                    state_d = SWEEP;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                addr_d = addr_q + ADDR_ONE;
                if (addr_q == ADDR_LAST) state_d = ACK;
            end
            ACK: begin
                if (!bus.ttehash_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (state_q == SWEEP) begin
            valid_q[addr_q] <= 1'b0;
        end else if (do_clr) begin
            valid_q[bus.hash] <= 1'b0;
        end else if (do_upd) begin
            valid_q[bus.hash] <= 1'b1;
        end
    end

    // Key RAM: read-before-write on a same-index update and lookup
    always_ff @(posedge clk) begin
        if (do_upd) mem[bus.hash] <= bus.flow;
        rd_key_q <= mem[bus.lk_hash];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_flow_q  <= '0;
            res_vld_q  <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            s1_vld_q   <= bus.lk_valid;
            s1_valid_q <= idle && valid_q[bus.lk_hash];
            s1_flow_q  <= bus.lk_flow;
            res_vld_q  <= s1_vld_q;
            hit_q      <= s1_vld_q && s1_valid_q && (rd_key_q == s1_flow_q);
        end
    end

    assign bus.ttehash_ack  = (state_q == ACK);
    assign bus.busy         = !idle;
    assign bus.entry_cnt    = cnt_q;
    assign bus.lk_res_valid = res_vld_q;
    assign bus.lk_hit       = hit_q;

`ifdef TTEHASH_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (!idle && (bus.hash_update || bus.hash_clear) && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign bus.drop_cnt = drop_q;
`endif
endmodule
